// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a valid/ready memory port and fills the IF/ID register.
// Latency 1 cycle from memory transfer to ifid_valid; a stall parks one word in a skid buffer, a redirect flushes.
module fetch_stage #(
    parameter int unsigned           XLEN      = 32,
    parameter logic [XLEN-1:0]       RESET_PC  = '0,
    parameter logic [31:0]           NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic [1:0]      ex_redir_sel,
    input  logic [XLEN-1:0] ex_pc_target,
    input  logic [XLEN-1:0] ex_jump_addr,
    output logic            ifid_valid,
    output logic [XLEN-1:0] ifid_pc,
    output logic [XLEN-1:0] ifid_pc_plus4,
    output logic [31:0]     ifid_instr
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_e;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] drop_addr_q, drop_addr_d;
    logic            skid_vld_q, skid_vld_d;
    logic [XLEN-1:0] skid_pc_q, skid_pc_d;
    logic [31:0]     skid_instr_q, skid_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [XLEN-1:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;

    logic            redir;
    logic [XLEN-1:0] redir_tgt;
    logic            xfer;

    assign redir     = (ex_redir_sel == 2'b01) || (ex_redir_sel == 2'b10);
    assign redir_tgt = (ex_redir_sel == 2'b01) ? ex_pc_target : {ex_jump_addr[XLEN-1:1], 1'b0};

    // While a discarded request is still outstanding the bus keeps its old address;
    // the redirect target waits in pc_q until that request completes.
    assign imem_req  = !rst && (state_q != S_HOLD);
    assign imem_addr = (state_q == S_DROP) ? drop_addr_q : pc_q;
    assign xfer      = imem_req && imem_ready;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        skid_vld_d   = skid_vld_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;

        if (redir) begin
            pc_d         = redir_tgt;
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_vld_d   = 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d = S_REQ;
                    end else begin
                        state_d     = S_DROP;
                        drop_addr_d = pc_q;
                    end
                end
                S_DROP:  state_d = imem_ready ? S_REQ : S_DROP;
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (xfer) begin
                        pc_d = pc_q + FOUR;
                        if (stall) begin
                            skid_vld_d   = 1'b1;
                            skid_pc_d    = pc_q;
                            skid_instr_d = imem_rdata;
                            state_d      = S_HOLD;
                        end else begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = pc_q;
                            ifid_pc4_d   = pc_q + FOUR;
                            ifid_instr_d = imem_rdata;
                        end
                    end else if (!stall) begin
                        ifid_valid_d = 1'b0;
                        ifid_instr_d = NOP_INSTR;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        ifid_valid_d = skid_vld_q;
                        ifid_pc_d    = skid_pc_q;
                        ifid_pc4_d   = skid_pc_q + FOUR;
                        ifid_instr_d = skid_vld_q ? skid_instr_q : NOP_INSTR;
                        skid_vld_d   = 1'b0;
                        state_d      = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ready) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            drop_addr_q  <= RESET_PC;
            skid_vld_q   <= 1'b0;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_pc4_q   <= '0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            skid_vld_q   <= skid_vld_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid    = ifid_valid_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus4 = ifid_pc4_q;
    assign ifid_instr    = ifid_instr_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random traffic, checked every cycle against a stream model.
module tb_fetch_stage;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] RSTPC = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  ex_redir_sel;
    logic [31:0] ex_pc_target;
    logic [31:0] ex_jump_addr;
    logic        ifid_valid;
    logic [31:0] ifid_pc;
    logic [31:0] ifid_pc_plus4;
    logic [31:0] ifid_instr;

    fetch_stage #(.XLEN(32), .RESET_PC(RSTPC), .NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .ex_redir_sel  (ex_redir_sel),
        .ex_pc_target  (ex_pc_target),
        .ex_jump_addr  (ex_jump_addr),
        .ifid_valid    (ifid_valid),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_instr    (ifid_instr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory content is a pure function of the address, so any delivered word identifies its PC.
    assign imem_rdata = imem_addr ^ 32'h0000_00A5;

    int n_cmp = 0;
    int n_err = 0;

    // Model: the instruction stream is contiguous from the last reset/redirect target.
    logic [31:0] exp_pc;
    logic        p_rst, p_stall, p_req, p_rdy;
    logic [1:0]  p_sel;
    logic [31:0] p_addr, p_tgt, p_jmp;
    logic        o_valid;
    logic [31:0] o_pc, o_instr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        #1;
        p_rst   = rst;
        p_stall = stall;
        p_sel   = ex_redir_sel;
        p_tgt   = ex_pc_target;
        p_jmp   = ex_jump_addr;
        p_req   = imem_req;
        p_rdy   = imem_ready;
        p_addr  = imem_addr;
        o_valid = ifid_valid;
        o_pc    = ifid_pc;
        o_instr = ifid_instr;
        @(posedge clk);
        #1;
        if (p_rst) begin
            chk("m_rst_valid", 32'(ifid_valid), 32'd0);
            chk("m_rst_instr", ifid_instr, NOP);
            chk("m_rst_pc", ifid_pc, 32'd0);
            exp_pc = RSTPC;
        end else if (p_sel == 2'b01 || p_sel == 2'b10) begin
            chk("m_redir_valid", 32'(ifid_valid), 32'd0);
            chk("m_redir_instr", ifid_instr, NOP);
            exp_pc = (p_sel == 2'b01) ? p_tgt : (p_jmp & 32'hFFFF_FFFE);
        end else if (p_stall) begin
            chk("m_stall_valid", 32'(ifid_valid), 32'(o_valid));
            chk("m_stall_pc", ifid_pc, o_pc);
            chk("m_stall_instr", ifid_instr, o_instr);
        end else if (ifid_valid) begin
            chk("m_pc", ifid_pc, exp_pc);
            chk("m_pc4", ifid_pc_plus4, exp_pc + 32'd4);
            chk("m_instr", ifid_instr, exp_pc ^ 32'h0000_00A5);
            exp_pc = exp_pc + 32'd4;
        end else begin
            chk("m_bubble_instr", ifid_instr, NOP);
        end
        if (!p_rst && !rst && p_req && !p_rdy) begin
            chk("m_req_held", 32'(imem_req), 32'd1);
            chk("m_addr_stable", imem_addr, p_addr);
        end
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b1; stall = 1'b0;
        ex_redir_sel = 2'b00; ex_pc_target = '0; ex_jump_addr = '0;
        exp_pc = RSTPC;
        tick();
        tick();
        chk("rst_valid", 32'(ifid_valid), 32'd0);
        chk("rst_instr", ifid_instr, NOP);
        chk("rst_pc4", ifid_pc_plus4, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);

        // T1: back-to-back fetch, IF/ID one cycle behind the address
        rst = 1'b0;
        #1;
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr0", imem_addr, 32'h0);
        tick();
        chk("t1_addr4", imem_addr, 32'h4);
        chk("t1_ifid0", ifid_pc, 32'h0);
        chk("t1_instr0", ifid_instr, 32'hA5);
        tick();
        chk("t1_addr8", imem_addr, 32'h8);
        chk("t1_ifid4", ifid_pc, 32'h4);

        // T2: wait states at 0x8
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_addr", imem_addr, 32'h8);
            chk("t2_valid", 32'(ifid_valid), 32'd0);
        end
        imem_ready = 1'b1;
        tick();
        chk("t2_pc", ifid_pc, 32'h8);
        chk("t2_instr", ifid_instr, 32'hAD);
        tick();
        chk("t2_next", ifid_pc, 32'hC);

        // T3: stall while 0x10 completes
        stall = 1'b1;
        tick();
        chk("t3_hold1", ifid_pc, 32'hC);
        chk("t3_req", 32'(imem_req), 32'd0);
        tick();
        chk("t3_hold2", ifid_pc, 32'hC);
        stall = 1'b0;
        tick();
        chk("t3_skid_pc", ifid_pc, 32'h10);
        chk("t3_skid_valid", 32'(ifid_valid), 32'd1);
        chk("t3_addr", imem_addr, 32'h14);

        // T4: redirect with the 0x14 request still outstanding
        ex_redir_sel = 2'b01; ex_pc_target = 32'h100; imem_ready = 1'b0;
        tick();
        chk("t4_flush", ifid_instr, NOP);
        chk("t4_addr_held", imem_addr, 32'h14);
        ex_redir_sel = 2'b00;
        tick();
        chk("t4_addr_held2", imem_addr, 32'h14);
        imem_ready = 1'b1;
        tick();
        chk("t4_drop_valid", 32'(ifid_valid), 32'd0);
        chk("t4_new_addr", imem_addr, 32'h100);
        tick();
        chk("t4_first", ifid_pc, 32'h100);

        // T5: jalr redirect beats a stall; bit 0 of the target is cleared
        stall = 1'b1; ex_redir_sel = 2'b10; ex_jump_addr = 32'h203;
        tick();
        chk("t5_flush", 32'(ifid_valid), 32'd0);
        chk("t5_addr", imem_addr, 32'h202);
        stall = 1'b0; ex_redir_sel = 2'b00;
        tick();
        chk("t5_pc", ifid_pc, 32'h202);

        // T6: reset abandons an outstanding request at 0x40
        ex_redir_sel = 2'b01; ex_pc_target = 32'h40;
        tick();
        ex_redir_sel = 2'b00; imem_ready = 1'b0;
        tick();
        chk("t6_addr40", imem_addr, 32'h40);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_addr", imem_addr, RSTPC);
        chk("t6_valid", 32'(ifid_valid), 32'd0);
        chk("t6_instr", ifid_instr, NOP);
        imem_ready = 1'b1;
        tick();

        // PC wrap-around and the 11 "no redirect" code
        ex_redir_sel = 2'b01; ex_pc_target = 32'hFFFF_FFF8;
        tick();
        ex_redir_sel = 2'b11;
        tick();
        tick();
        chk("wrap_pc", ifid_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4", ifid_pc_plus4, 32'h0);
        ex_redir_sel = 2'b00;
        tick();
        chk("wrap_zero", ifid_pc, 32'h0);

        // Random traffic against the stream model
        for (int i = 0; i < 600; i++) begin
            imem_ready   = ($urandom_range(0, 3) != 0);
            stall        = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 9))
                0:       ex_redir_sel = 2'b01;
                1:       ex_redir_sel = 2'b10;
                2:       ex_redir_sel = 2'b11;
                default: ex_redir_sel = 2'b00;
            endcase
            ex_pc_target = $urandom() & 32'hFFFF_FFFC;
            ex_jump_addr = $urandom();
            rst          = ($urandom_range(0, 99) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
